// File: rtl/mem_arbiter_if.sv
// Bundled bus between the two cache-side requesters, the arbiter and the memory controller.
// Port 1 (icache) uses the upper half of each packed field and port 0 (dcache) the lower half.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int MASK_WIDTH = DATA_WIDTH / 8;

   logic [3:0]              req_rw_flag_i;
   logic [2*ADDR_WIDTH-1:0] req_addr_i;
   logic [2*DATA_WIDTH-1:0] req_w_data_i;
   logic [2*MASK_WIDTH-1:0] req_w_mask_i;
   logic [2*DATA_WIDTH-1:0] req_r_data_o;
   logic [1:0]              req_busy_o;
   logic [1:0]              req_done_o;
   logic [1:0]              mem_rw_flag_o;
   logic [ADDR_WIDTH-1:0]   mem_addr_o;
   logic [DATA_WIDTH-1:0]   mem_w_data_o;
   logic [MASK_WIDTH-1:0]   mem_w_mask_o;
   logic [DATA_WIDTH-1:0]   mem_r_data_i;
   logic                    mem_busy_i;
   logic                    mem_done_i;

   modport slave (
      input  req_rw_flag_i, req_addr_i, req_w_data_i, req_w_mask_i,
      input  mem_r_data_i, mem_busy_i, mem_done_i,
      output req_r_data_o, req_busy_o, req_done_o,
      output mem_rw_flag_o, mem_addr_o, mem_w_data_o, mem_w_mask_o
   );

   modport master (
      output req_rw_flag_i, req_addr_i, req_w_data_i, req_w_mask_i,
      output mem_r_data_i, mem_busy_i, mem_done_i,
      input  req_r_data_o, req_busy_o, req_done_o,
      input  mem_rw_flag_o, mem_addr_o, mem_w_data_o, mem_w_mask_o
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the icache (port 1) and dcache (port 0).
// Each grant runs IDLE -> ACTIVE -> RESP and ends with a one-cycle done pulse to its owner.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);
   localparam int MASK_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

   state_t                state;
   logic                  owner;
   logic                  prio;
   logic [1:0]            mask_next;

   logic [1:0]            port_req;
   logic [1:0]            eligible;
   logic                  grant_port;
   logic [1:0]            sel_flag;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [MASK_WIDTH-1:0] sel_mask;

   // A port that just completed sits out one IDLE cycle; prio only matters on a tie.
   always_comb begin
      port_req   = {|bus.req_rw_flag_i[3:2], |bus.req_rw_flag_i[1:0]};
      eligible   = port_req & ~mask_next;
      grant_port = (eligible == 2'b11) ? prio : eligible[1];
      sel_flag   = grant_port ? bus.req_rw_flag_i[3:2] : bus.req_rw_flag_i[1:0];
      sel_addr   = grant_port ? bus.req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                              : bus.req_addr_i[ADDR_WIDTH-1:0];
      sel_data   = grant_port ? bus.req_w_data_i[2*DATA_WIDTH-1:DATA_WIDTH]
                              : bus.req_w_data_i[DATA_WIDTH-1:0];
      sel_mask   = grant_port ? bus.req_w_mask_i[2*MASK_WIDTH-1:MASK_WIDTH]
                              : bus.req_w_mask_i[MASK_WIDTH-1:0];
   end

   // The memory-side output registers double as the latched request while ACTIVE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state             <= IDLE;
         owner             <= 1'b0;
         prio              <= 1'b0;
         mask_next         <= 2'b00;
         bus.mem_rw_flag_o <= 2'b00;
         bus.mem_addr_o    <= '0;
         bus.mem_w_data_o  <= '0;
         bus.mem_w_mask_o  <= '0;
         bus.req_r_data_o  <= '0;
         bus.req_busy_o    <= 2'b00;
         bus.req_done_o    <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               mask_next <= 2'b00;
               if (!bus.mem_busy_i && eligible != 2'b00) begin
                  owner             <= grant_port;
                  prio              <= ~grant_port;
                  bus.mem_rw_flag_o <= sel_flag[1] ? 2'b10 : 2'b01;
                  bus.mem_addr_o    <= sel_addr;
                  bus.mem_w_data_o  <= sel_flag[1] ? sel_data : '0;
                  bus.mem_w_mask_o  <= sel_flag[1] ? sel_mask : '0;
                  bus.req_busy_o    <= 2'b11;
                  state             <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (bus.mem_done_i) begin
                  if (bus.mem_rw_flag_o == 2'b01) begin
                     if (owner)
                        bus.req_r_data_o[2*DATA_WIDTH-1:DATA_WIDTH] <= bus.mem_r_data_i;
                     else
                        bus.req_r_data_o[DATA_WIDTH-1:0] <= bus.mem_r_data_i;
                  end
                  bus.mem_rw_flag_o <= 2'b00;
                  bus.req_done_o    <= owner ? 2'b10 : 2'b01;
                  bus.req_busy_o    <= owner ? 2'b01 : 2'b10;
                  state             <= RESP;
               end
            end
            RESP: begin
               bus.req_done_o <= 2'b00;
               bus.req_busy_o <= 2'b00;
               mask_next      <= owner ? 2'b10 : 2'b01;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: requester and memory models drive the bus while a
// timestamp-based reference model predicts every registered output each cycle.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int errors = 0;
   int checks = 0;

   // requester and memory stimulus state
   bit          pend [2];
   logic [1:0]  req_op [2];
   logic [31:0] req_addr [2];
   logic [31:0] req_data [2];
   logic [3:0]  req_mask [2];
   logic [1:0]  req_flag [2];
   logic        mem_busy, mem_done;
   logic [31:0] mem_rdata, mem_fix;
   bit          mem_fix_en, force_busy;
   int          mem_lat = -1, cd = -1;
   int          new_pct = 0, busy_pct = 0, spur_pct = 0, rst_permil = 0;

   // reference model: transaction timestamps rather than a state register
   int          cyc = 0;
   bit          m_txn, m_reset;
   int          m_gcyc, m_mdcyc, m_own, m_fav;
   int          m_last_done [2];
   logic [1:0]  m_op;
   logic [31:0] m_addr, m_data;
   logic [3:0]  m_mask;
   logic [63:0] m_rdata;

   // observation records used by the directed checks
   logic [1:0]  done_seq [$];
   int          gap_seq [$];
   logic [1:0]  exp_q [$];
   int          zero_run, first_flag_cyc, first_done_cyc;
   bit          seen_txn;
   logic [1:0]  ff_flag;
   logic [31:0] ff_addr, ff_data;
   logic [3:0]  ff_mask;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic void model_step();
      int  c = cyc;
      bit  idle_c, active_c;
      bit  [1:0] elig;
      int  pick;
      m_reset = 1'b0;
      if (!rst) begin
         m_txn = 1'b0; m_fav = 0; m_rdata = '0; m_reset = 1'b1;
         m_last_done[0] = -10; m_last_done[1] = -10;
         return;
      end
      idle_c   = !m_txn || (m_mdcyc >= 0 && c >= m_mdcyc + 2);
      active_c = m_txn && c > m_gcyc && m_mdcyc < 0;
      if (active_c) begin
         if (mem_done) begin
            m_mdcyc = c;
            m_last_done[m_own] = c + 1;
            if (m_op == 2'b01) begin
               if (m_own == 1) m_rdata[63:32] = mem_rdata;
               else            m_rdata[31:0]  = mem_rdata;
            end
         end
      end else if (idle_c) begin
         elig = 2'b00;
         for (int p = 0; p < 2; p++)
            elig[p] = (req_flag[p] != 2'b00) && (m_last_done[p] != c - 1);
         if (!mem_busy && elig != 2'b00) begin
            pick   = (elig == 2'b11) ? m_fav : (elig[1] ? 1 : 0);
            m_fav  = 1 - pick;
            m_txn  = 1'b1; m_gcyc = c; m_mdcyc = -1; m_own = pick;
            m_op   = req_flag[pick][1] ? 2'b10 : 2'b01;
            m_addr = req_addr[pick];
            m_data = (m_op == 2'b10) ? req_data[pick] : 32'h0;
            m_mask = (m_op == 2'b10) ? req_mask[pick] : 4'h0;
         end
      end
   endfunction

   task automatic check_cycle();
      int d = cyc;
      bit on, pulse;
      logic [1:0] e_done, e_busy;
      if (m_reset) begin
         checkOutput("reset_flag", bus.mem_rw_flag_o, 0);
         checkOutput("reset_addr", bus.mem_addr_o, 0);
         checkOutput("reset_wdata", bus.mem_w_data_o, 0);
         checkOutput("reset_wmask", bus.mem_w_mask_o, 0);
         checkOutput("reset_done", bus.req_done_o, 0);
         checkOutput("reset_busy", bus.req_busy_o, 0);
         checkOutput("reset_rdata", bus.req_r_data_o, 0);
         return;
      end
      on     = m_txn && d > m_gcyc && (m_mdcyc < 0 || d <= m_mdcyc);
      pulse  = m_txn && m_mdcyc >= 0 && d == m_mdcyc + 1;
      e_done = pulse ? ((m_own == 1) ? 2'b10 : 2'b01) : 2'b00;
      e_busy = on ? 2'b11 : (pulse ? ((m_own == 1) ? 2'b01 : 2'b10) : 2'b00);
      checkOutput("mem_flag", bus.mem_rw_flag_o, on ? m_op : 2'b00);
      checkOutput("req_done", bus.req_done_o, e_done);
      checkOutput("req_busy", bus.req_busy_o, e_busy);
      checkOutput("req_rdata", bus.req_r_data_o, m_rdata);
      if (on) begin
         checkOutput("mem_addr", bus.mem_addr_o, m_addr);
         checkOutput("mem_wdata", bus.mem_w_data_o, m_data);
         checkOutput("mem_wmask", bus.mem_w_mask_o, m_mask);
      end
   endtask

   function automatic void track();
      if (bus.req_done_o != 2'b00) begin
         done_seq.push_back(bus.req_done_o);
         if (first_done_cyc < 0) first_done_cyc = cyc;
      end
      if (bus.mem_rw_flag_o == 2'b00) zero_run++;
      else begin
         if (zero_run > 0 && seen_txn) gap_seq.push_back(zero_run);
         if (first_flag_cyc < 0) begin
            first_flag_cyc = cyc;
            ff_flag = bus.mem_rw_flag_o; ff_addr = bus.mem_addr_o;
            ff_data = bus.mem_w_data_o;  ff_mask = bus.mem_w_mask_o;
         end
         zero_run = 0;
         seen_txn = 1'b1;
      end
   endfunction

   function automatic void clear_track();
      done_seq.delete(); gap_seq.delete();
      zero_run = 0; seen_txn = 1'b0; first_flag_cyc = -1; first_done_cyc = -1;
   endfunction

   task automatic applyStimulus();
      bus.req_rw_flag_i = {req_flag[1], req_flag[0]};
      bus.req_addr_i    = {req_addr[1], req_addr[0]};
      bus.req_w_data_i  = {req_data[1], req_data[0]};
      bus.req_w_mask_i  = {req_mask[1], req_mask[0]};
      bus.mem_busy_i    = mem_busy;
      bus.mem_done_i    = mem_done;
      bus.mem_r_data_i  = mem_rdata;
      model_step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      check_cycle();
      track();
   endtask

   function automatic void set_req(input int p, input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] d, input logic [3:0] m);
      pend[p] = 1'b1; req_op[p] = op; req_addr[p] = a; req_data[p] = d; req_mask[p] = m;
   endfunction

   // One cycle of requester and memory behaviour, decided from the outputs just observed.
   task automatic autoCycle();
      for (int p = 0; p < 2; p++) begin
         if (bus.req_done_o[p] === 1'b1) pend[p] = 1'b0;
         if (!pend[p] && $urandom_range(99) < new_pct)
            set_req(p, 2'($urandom_range(3, 1)), $urandom, $urandom, 4'($urandom));
         req_flag[p] = pend[p] ? req_op[p] : 2'b00;
      end
      mem_done = 1'b0;
      if (bus.mem_rw_flag_o != 2'b00) begin
         if (cd < 0) cd = (mem_lat >= 0) ? mem_lat : int'($urandom_range(4));
         if (cd == 0) begin
            mem_done  = 1'b1;
            mem_rdata = mem_fix_en ? mem_fix : $urandom;
            cd        = -1;
         end else cd--;
      end else begin
         cd        = -1;
         mem_done  = ($urandom_range(99) < spur_pct);
         mem_rdata = $urandom;
      end
      mem_busy = force_busy || ($urandom_range(99) < busy_pct);
      if (rst_permil > 0) rst = ($urandom_range(999) < rst_permil) ? 1'b0 : 1'b1;
      applyStimulus();
   endtask

   task automatic run_until(input string tag, input int ndone, input int maxc);
      int k = 0;
      while (done_seq.size() < ndone && k < maxc) begin
         autoCycle();
         k++;
      end
      if (done_seq.size() < ndone) checkOutput(tag, done_seq.size(), ndone);
   endtask

   task automatic check_dones(input string tag);
      for (int i = 0; i < exp_q.size(); i++)
         checkOutput(tag, (i < done_seq.size()) ? done_seq[i] : 2'bxx, exp_q[i]);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) autoCycle();
   endtask

   initial begin
      logic [31:0] lo_before;
      int k, start;
      rst = 1'b0;
      for (int p = 0; p < 2; p++) begin
         pend[p] = 1'b0; req_op[p] = 2'b00; req_addr[p] = '0;
         req_data[p] = '0; req_mask[p] = '0; req_flag[p] = 2'b00;
      end
      mem_busy = 1'b0; mem_done = 1'b0; mem_rdata = '0; mem_fix = '0;
      mem_fix_en = 1'b0; force_busy = 1'b0;
      bus.req_rw_flag_i = '0; bus.req_addr_i = '0; bus.req_w_data_i = '0; bus.req_w_mask_i = '0;
      bus.mem_busy_i = 1'b0; bus.mem_done_i = 1'b0; bus.mem_r_data_i = '0;
      clear_track();
      @(negedge clk);

      $display("[TB] reset with both ports requesting");
      set_req(0, 2'b01, 32'h0000_0100, 32'h0, 4'h0);
      set_req(1, 2'b01, 32'h0000_0200, 32'h0, 4'h0);
      mem_fix_en = 1'b1; mem_fix = 32'h0A0A_0A0A; mem_lat = 1;
      repeat (3) autoCycle();
      rst = 1'b1;
      clear_track();
      autoCycle();
      checkOutput("rst_first_flag", bus.mem_rw_flag_o, 2'b01);
      checkOutput("rst_first_addr", bus.mem_addr_o, 32'h0000_0100);
      run_until("rst_timeout", 2, 40);
      exp_q = {2'b01, 2'b10};
      check_dones("rst_order");
      idle_cycles(4);

      $display("[TB] single icache read");
      clear_track();
      set_req(1, 2'b01, 32'h0000_1000, 32'h0, 4'h0);
      mem_fix = 32'hDEAD_BEEF; mem_lat = 3;
      run_until("read_timeout", 1, 30);
      exp_q = {2'b10};
      check_dones("read_done");
      checkOutput("read_latency", first_done_cyc - first_flag_cyc, 4);
      checkOutput("read_hi", bus.req_r_data_o[63:32], 32'hDEAD_BEEF);
      checkOutput("read_lo", bus.req_r_data_o[31:0], 32'h0A0A_0A0A);
      idle_cycles(4);

      $display("[TB] contention");
      clear_track();
      mem_fix_en = 1'b0; mem_lat = -1; new_pct = 100;
      set_req(0, 2'b01, $urandom, $urandom, 4'h0);
      set_req(1, 2'b10, $urandom, $urandom, 4'hF);
      run_until("fair_timeout", 6, 120);
      new_pct = 0;
      k = 0;
      while ((pend[0] || pend[1]) && k < 40) begin autoCycle(); k++; end
      exp_q = {2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
      check_dones("fair_order");
      for (int i = 0; i < 5; i++)
         checkOutput("fair_gap", (i < gap_seq.size()) ? gap_seq[i] : -1, 2);
      idle_cycles(4);

      $display("[TB] writes");
      clear_track();
      lo_before = m_rdata[31:0];
      mem_fix_en = 1'b1; mem_fix = 32'hAAAA_5555; mem_lat = 2;
      set_req(0, 2'b10, 32'h0000_0040, 32'h1234_5678, 4'b0011);
      run_until("write_timeout", 1, 30);
      checkOutput("write_flag", ff_flag, 2'b10);
      checkOutput("write_addr", ff_addr, 32'h0000_0040);
      checkOutput("write_data", ff_data, 32'h1234_5678);
      checkOutput("write_mask", ff_mask, 4'b0011);
      checkOutput("write_rdata_kept", bus.req_r_data_o[31:0], lo_before);
      idle_cycles(4);
      clear_track();
      set_req(0, 2'b11, 32'h0000_0044, 32'hCAFE_F00D, 4'b1100);
      run_until("write11_timeout", 1, 30);
      checkOutput("write11_flag", ff_flag, 2'b10);
      checkOutput("write11_data", ff_data, 32'hCAFE_F00D);
      checkOutput("write11_mask", ff_mask, 4'b1100);
      idle_cycles(4);

      $display("[TB] memory busy");
      clear_track();
      start = cyc;
      set_req(1, 2'b01, 32'h0000_2000, 32'h0, 4'h0);
      force_busy = 1'b1;
      repeat (5) autoCycle();
      force_busy = 1'b0;
      run_until("busy_timeout", 1, 30);
      checkOutput("busy_grant_cycle", first_flag_cyc - start, 6);
      exp_q = {2'b10};
      check_dones("busy_done");
      idle_cycles(4);

      $display("[TB] reset mid-transaction");
      clear_track();
      mem_lat = 50; mem_fix = 32'h5A5A_0001;
      set_req(0, 2'b01, 32'h0000_0300, 32'h0, 4'h0);
      k = 0;
      while (bus.mem_rw_flag_o == 2'b00 && k < 10) begin autoCycle(); k++; end
      checkOutput("abort_granted", bus.mem_rw_flag_o, 2'b01);
      mem_lat = 2;
      rst = 1'b0;
      autoCycle();
      rst = 1'b1; spur_pct = 100;
      autoCycle();
      spur_pct = 0;
      checkOutput("abort_no_done", bus.req_done_o, 2'b00);
      run_until("abort_timeout", 1, 30);
      exp_q = {2'b01};
      check_dones("abort_done");
      checkOutput("abort_done_count", done_seq.size(), 1);
      checkOutput("abort_rdata", bus.req_r_data_o[31:0], 32'h5A5A_0001);
      idle_cycles(4);

      $display("[TB] random traffic");
      mem_fix_en = 1'b0; mem_lat = -1;
      new_pct = 30; busy_pct = 20; spur_pct = 5; rst_permil = 5;
      repeat (3000) autoCycle();
      new_pct = 0; busy_pct = 0; spur_pct = 0; rst_permil = 0; rst = 1'b1;
      idle_cycles(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester, one-port memory arbiter. It lets the instruction cache and the data cache share a single external memory port. It sits between the packed cache-side memory buses (port 1 = icache, port 0 = dcache, same packing as the CPU top's `mem_*` buses) and one memory controller. Each transaction is granted in round-robin order, sequenced through a 3-state FSM, and completed with a one-cycle `done` pulse to its owner.

## Interface
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width; mask width is `DATA_WIDTH/8`
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous reset, active-low
- `req_rw_flag_i`  in  4  per port {write,read}; port p at [2p+1:2p]
- `req_addr_i`  in  2*ADDR_WIDTH  per-port address; port p at upper/lower half
- `req_w_data_i`  in  2*DATA_WIDTH  per-port write data
- `req_w_mask_i`  in  8  per-port byte mask
- `req_r_data_o`  out  2*DATA_WIDTH  per-port read data, registered
- `req_busy_o`  out  2  per-port busy
- `req_done_o`  out  2  per-port completion pulse
- `mem_rw_flag_o`  out  2  {write,read} to memory
- `mem_addr_o`  out  ADDR_WIDTH  memory address
- `mem_w_data_o`  out  DATA_WIDTH  memory write data
- `mem_w_mask_o`  out  4  memory byte mask
- `mem_r_data_i`  in  DATA_WIDTH  memory read data, valid with `mem_done_i`
- `mem_busy_i`  in  1  memory cannot accept a new request
- `mem_done_i`  in  1  one-cycle completion from memory

## Operation
- A port requests when its 2-bit flag is nonzero. If both bits are set (2'b11), the request is treated as a write.
- A requester holds flag, addr, data and mask stable until its `done` pulse.
- Registers: `state` (IDLE/ACTIVE/RESP), `owner` (1 bit), `prio` (port favoured on tie), `mask_next[1:0]` (cooldown), latched address/data/mask/op.
- IDLE:
  - A port is eligible if its flag ≠ 0 and its `mask_next` bit is 0.
  - If `mem_busy_i` = 1, nothing is granted.
  - If one port is eligible, grant it.
  - If both are eligible, grant `prio`, then set `prio` to the other port.
  - If a single port is granted, set `prio` to the non-granted port.
  - On grant: latch the request, set `owner`, go to ACTIVE.
- ACTIVE:
  - Drive `mem_rw_flag_o` (read = 2'b01, write = 2'b10) plus the latched addr/data/mask. On a read, drive mask = 0 and w_data = 0.
  - Hold everything until `mem_done_i` = 1, then capture `mem_r_data_i` (reads only) into the owner's `req_r_data_o` slice and go to RESP.
- RESP:
  - `mem_rw_flag_o` = 0.
  - `req_done_o[owner]` = 1 for this cycle only.
  - Set `mask_next[owner]`; next state is IDLE.
- Cooldown: `mask_next` bits clear after one IDLE cycle. The completed port therefore cannot be re-granted the cycle immediately after its `done`, which gives the requester time to drop its flag.
- `req_busy_o[p]` = 1 when state ≠ IDLE, except in RESP when p = owner.
- `req_r_data_o` slices hold their value until the next read completion for that port. Writes leave them unchanged.
- `mem_done_i` in IDLE or RESP is ignored.

## Timing
- Reset (`rst` = 0 at an edge):
  - state = IDLE, `prio` = 0 (dcache first), `mask_next` = 0.
  - All outputs = 0, including `req_r_data_o`.
  - An in-flight transaction is abandoned with no `done`.
- All outputs are registered.
- Latency, request first seen in cycle 0:
  - Memory flag is asserted in cycle 1.
  - `mem_done_i` in cycle n ≥ 1 gives `req_done_o` in cycle n+1.
  - Minimum round trip is 2 cycles.
- Back-to-back: the other port's pending request can be granted in the IDLE cycle right after RESP, so `mem_rw_flag_o` = 0 for exactly 2 cycles between transactions.
- Simultaneous request and `mem_busy_i` = 1 in IDLE: no grant, `prio` unchanged.
- A flag dropped before grant is a cancelled request. Dropping a flag after grant violates the requester contract and is undefined.

## Test plan
- Reset: hold `rst` = 0 for 3 cycles with both ports requesting → all outputs 0. Release → port 0 is granted first; `mem_addr_o` = port 0 address in cycle 1.
- Single read: port 1 reads 0x0000_1000, memory returns 0xDEAD_BEEF with `mem_done_i` 3 cycles after the flag → `req_done_o` = 2'b10 for one cycle; `req_r_data_o[63:32]` = 0xDEAD_BEEF; port 0 slice unchanged.
- Contention/fairness: both ports request continuously for 6 transactions → grant order 0,1,0,1,0,1; each `done` matches its port; 2-cycle gap between memory flags.
- Write: port 0 writes 0x1234_5678, mask 4'b0011, address 0x40 → memory sees flag 2'b10, mask 4'b0011, data 0x1234_5678; `req_r_data_o[31:0]` unchanged. A flag of 2'b11 also issues a write.
- `mem_busy_i` = 1 for 5 cycles with port 1 requesting → no memory flag until the cycle after busy drops; then a normal completion.
- Reset mid-ACTIVE: assert `rst` = 0 before `mem_done_i` → IDLE next cycle, no `done`. A later `mem_done_i` is ignored and the next request is served normally.
